click_sync_sink: RTL and testbench

//  Clocked receiving end of the 2-phase click handshake (inR/inA toggle protocol, bundled data).

---
 rtl/click_pkg.sv | 33 +++
 rtl/click_req_sync.sv | 27 ++
 rtl/click_sync_sink.sv | 92 +++++++++
 tb/tb_click_sync_sink.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/click_pkg.sv
// Shared definitions for the click handshake endpoints: reset phase, default
// geometry and the width helper used for pointers and occupancy.
`timescale 1ns/1ps
package click_pkg;

  // Phase both ends of a click link settle to while reset is asserted.
  localparam logic CLICK_RESET_PHASE = 1'b0;

  localparam int CLICK_WIDTH       = 32;
  localparam int CLICK_DEPTH       = 4;
  localparam int CLICK_SYNC_STAGES = 2;

  // FIFO operation for one edge, encoded as {push, pop}.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifoOp_t;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/click_req_sync.sv
// Multi-flop synchroniser bringing the 2-phase click request into the clock
// domain; clears to the link reset phase.
`timescale 1ns/1ps
module click_req_sync
  import click_pkg::*;
#(
  parameter int SYNC_STAGES = CLICK_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic reqAsync,
  output logic reqSync
);

  logic [SYNC_STAGES-1:0] syncChain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncChain <= {SYNC_STAGES{CLICK_RESET_PHASE}};
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], reqAsync};
    end
  end

  assign reqSync = syncChain[SYNC_STAGES-1];

endmodule

// File: rtl/click_sync_sink.sv
// Clocked receiving end of a 2-phase click chain: synchronises inR, stores the
// bundled word in a small FIFO, returns inA as a toggle and offers FWFT output.
`timescale 1ns/1ps
module click_sync_sink
  import click_pkg::*;
#(
  parameter  int WIDTH       = CLICK_WIDTH,
  parameter  int DEPTH       = CLICK_DEPTH,
  parameter  int SYNC_STAGES = CLICK_SYNC_STAGES,
  localparam int PTR_W       = clog2(DEPTH),
  localparam int LEVEL_W     = clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inR,
  input  logic [WIDTH-1:0]   inD,
  output logic               inA,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

  logic               reqSync;
  logic               ackPhase;
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [LEVEL_W-1:0] levelQ;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic    pending;
  logic    full;
  logic    push;
  logic    pop;
  fifoOp_t fifoOp;

  click_req_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) reqSyncInst (
    .clk      (clk),
    .rst      (rst),
    .reqAsync (inR),
    .reqSync  (reqSync)
  );

  // A token is outstanding while the synchronised request and our ack differ.
  // Full is judged on the registered level, so a same-cycle pop never frees a slot early.
  always_comb begin
    pending   = (reqSync != ackPhase);
    full      = (levelQ == LEVEL_FULL);
    out_valid = (levelQ != '0);
    push      = pending & ~full;
    pop       = out_valid & out_ready;
    fifoOp    = fifoOp_t'({push, pop});
    out_data  = out_valid ? mem[rdPtr] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ackPhase <= CLICK_RESET_PHASE;
      wrPtr    <= '0;
      rdPtr    <= '0;
      levelQ   <= '0;
    end else begin
      if (push) begin
        ackPhase <= ~ackPhase;
        wrPtr    <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case (fifoOp)
        FIFO_PUSH: levelQ <= levelQ + LEVEL_W'(1);
        FIFO_POP:  levelQ <= levelQ - LEVEL_W'(1);
        default:   levelQ <= levelQ;
      endcase
    end
  end

  // Storage carries data only; validity lives entirely in levelQ.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= inD;
    end
  end

  assign inA   = ackPhase;
  assign level = levelQ;

endmodule

// File: tb/tb_click_sync_sink.sv
// Bench for click_sync_sink: directed handshake/full/reset cases plus randomized
// streams scored against a token-queue reference model.
`timescale 1ns/1ps
module tb_click_sync_sink;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int SYNC_ST = 2;
  localparam int LEVEL_W = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               inR = 1'b0;
  logic [WIDTH-1:0]   inD = '0;
  logic               out_ready = 1'b0;
  logic               inA;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [LEVEL_W-1:0] level;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] expQ [$];

  always #5 clk = ~clk;

  click_sync_sink #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_ST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inR       (inR),
    .inD       (inD),
    .inA       (inA),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level)
  );

  task automatic checkEq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Wait (bounded) until the link is idle: ack phase equals request phase.
  task automatic waitMatch(input string tag);
    int n;
    n = 0;
    while (inA !== inR && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkEq(tag, 64'(inA), 64'(inR));
  endtask

  task automatic sendToken(input string tag, input logic [WIDTH-1:0] d);
    waitMatch({tag, "Idle"});
    inD = d;
    inR = ~inR;
  endtask

  task automatic popExpect(input string tag, input logic [WIDTH-1:0] d);
    @(negedge clk);
    checkEq({tag, "Valid"}, 64'(out_valid), 64'(1));
    checkEq({tag, "Data"}, 64'(out_data), 64'(d));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Producer sends nTok random words; the consumer pops at readyPct percent and
  // every popped word must be the oldest unconsumed word sent.
  task automatic runStream(input int nTok, input int readyPct, input bit jitter, input string tag);
    bit   prodDone;
    int   acks;
    int   pops;
    int   cyc;
    logic prevInA;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] d;
    prodDone = 1'b0;
    acks     = 0;
    pops     = 0;
    cyc      = 0;
    expQ.delete();
    prevInA  = inA;
    fork
      begin
        for (int i = 0; i < nTok; i++) begin
          if (jitter) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            case ($urandom_range(0, 2))
              0:       #0.05;
              1:       #9.95;
              default: #($urandom_range(1, 99) / 10.0);
            endcase
          end else begin
            @(negedge clk);
          end
          d = $urandom;
          expQ.push_back(d);
          sendToken(tag, d);
          waitMatch({tag, "Ack"});
        end
        prodDone = 1'b1;
      end
      begin
        while (!(prodDone && expQ.size() == 0) && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (inA !== prevInA) acks++;
          prevInA = inA;
          checkEq({tag, "Level"}, 64'(level), 64'(acks - pops));
          checkEq({tag, "ValidFlag"}, 64'(out_valid), 64'(acks != pops));
          out_ready = ($urandom_range(1, 100) <= readyPct);
          if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
              checkEq({tag, "QueueSize"}, 64'(expQ.size()), 64'(1));
            end else begin
              head = expQ.pop_front();
              checkEq({tag, "Data"}, 64'(out_data), 64'(head));
              pops++;
            end
          end
        end
        checkEq({tag, "Timeout"}, 64'(cyc < 20000), 64'(1));
      end
    join
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkEq({tag, "AckCount"}, 64'(acks), 64'(nTok));
    checkEq({tag, "PopCount"}, 64'(pops), 64'(nTok));
    checkEq({tag, "EndLevel"}, 64'(level), 64'(0));
    checkEq({tag, "EndPhase"}, 64'(inA), 64'(inR));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while held in reset.
    #1;
    checkEq("rstInA", 64'(inA), 64'(0));
    checkEq("rstValid", 64'(out_valid), 64'(0));
    checkEq("rstLevel", 64'(level), 64'(0));
    checkEq("rstData", 64'(out_data), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 1: idle after release, no spurious push.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkEq($sformatf("t1InA%0d", c), 64'(inA), 64'(0));
      checkEq($sformatf("t1Valid%0d", c), 64'(out_valid), 64'(0));
      checkEq($sformatf("t1Level%0d", c), 64'(level), 64'(0));
    end

    // 2: single token, ack on the third rising edge.
    @(negedge clk);
    inD = 32'hA5A5_0001;
    inR = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      checkEq($sformatf("t2AckEdge%0d", e), 64'(inA), 64'(e >= 3));
    end
    checkEq("t2Level", 64'(level), 64'(1));
    checkEq("t2Valid", 64'(out_valid), 64'(1));
    checkEq("t2Data", 64'(out_data), 64'(32'hA5A5_0001));
    popExpect("t2Pop", 32'hA5A5_0001);
    checkEq("t2LevelAfterPop", 64'(level), 64'(0));

    // 3: fill, back-pressure on the fifth token, release by a single pop.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      sendToken("t3", WIDTH'(i));
      waitMatch("t3Ack");
    end
    checkEq("t3FullLevel", 64'(level), 64'(4));
    checkEq("t3Head", 64'(out_data), 64'(1));
    @(negedge clk);
    sendToken("t3Fifth", 32'd5);
    repeat (8) @(negedge clk);
    checkEq("t3FullHold", 64'(inA), 64'(1));
    checkEq("t3FullHoldLevel", 64'(level), 64'(4));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkEq("t3PopLevel", 64'(level), 64'(3));
    checkEq("t3PopAckHold", 64'(inA), 64'(1));
    @(posedge clk);
    #1;
    checkEq("t3LateAck", 64'(inA), 64'(0));
    checkEq("t3RefillLevel", 64'(level), 64'(4));
    for (int i = 2; i <= 5; i++) popExpect($sformatf("t3Drain%0d", i), WIDTH'(i));
    checkEq("t3EmptyLevel", 64'(level), 64'(0));
    checkEq("t3EmptyValid", 64'(out_valid), 64'(0));

    // 4: long stream with an always-ready consumer.
    runStream(1000, 100, 1'b0, "t4");

    // 5: asynchronous reset with three stored words and one token in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sendToken("t5", 32'h50 + WIDTH'(i));
      waitMatch("t5Ack");
    end
    checkEq("t5PreLevel", 64'(level), 64'(3));
    @(negedge clk);
    sendToken("t5Pend", 32'h99);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkEq("t5RstInA", 64'(inA), 64'(0));
    checkEq("t5RstValid", 64'(out_valid), 64'(0));
    checkEq("t5RstLevel", 64'(level), 64'(0));
    checkEq("t5RstData", 64'(out_data), 64'(0));
    inR = 1'b0;
    inD = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkEq($sformatf("t5IdleLevel%0d", c), 64'(level), 64'(0));
      checkEq($sformatf("t5IdleInA%0d", c), 64'(inA), 64'(0));
    end
    @(negedge clk);
    sendToken("t5Restart", 32'h1234_5678);
    waitMatch("t5RestartAck");
    checkEq("t5RestartLevel", 64'(level), 64'(1));
    checkEq("t5RestartData", 64'(out_data), 64'(32'h1234_5678));
    popExpect("t5RestartPop", 32'h1234_5678);

    // 6: request toggles at random phases, including just either side of an edge.
    runStream(300, 50, 1'b1, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
